// File: rtl/wb_master_pkg.sv
// Shared types and Wishbone cycle-type encodings for the burst master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWdata,
    StBus,
    StFin
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Single-beat bursts are plain classic cycles; longer ones mark their last beat.
  function automatic logic [2:0] cti_for(input logic [2:0] len, input logic [2:0] beat);
    if (len == 3'd0) begin
      return CTI_CLASSIC;
    end
    if (beat == len) begin
      return CTI_EOB;
    end
    return CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master: 1..8 beats per command, per-beat write data
// handshake, registered read data, and an ack timeout that abandons the burst.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 26,
  parameter int unsigned TMO = 255
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [2:0]      req_len,
  input  logic [DW/8-1:0] req_sel,
  input  logic            wr_valid,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_ready,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            done,
  output logic            err_tmo,
  output logic            wb_cyc_i,
  output logic            wb_stb_i,
  output logic            wb_we_i,
  output logic [AW-1:0]   wb_addr_i,
  output logic [DW-1:0]   wb_dat_i,
  output logic [DW/8-1:0] wb_sel_i,
  output logic [2:0]      wb_cti_i,
  input  logic            wb_ack_o,
  input  logic [DW-1:0]   wb_dat_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = $clog2(TMO + 1);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      len_q, len_d;
  logic [2:0]      beat_q, beat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            last_beat;

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    tmo_d      = '0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_data_d  = rd_data_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          len_d   = req_len;
          sel_d   = req_sel;
          beat_d  = 3'd0;
          state_d = req_we ? StWdata : StBus;
        end
      end
      StWdata: begin
        if (wr_valid) begin
          wdat_d  = wr_data;
          state_d = StBus;
        end
      end
      StBus: begin
        // An ack in the timeout cycle still completes the beat.
        if (wb_ack_o) begin
          addr_d = addr_q + AW'(1);
          beat_d = beat_q + 3'd1;
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_last_d  = last_beat;
            rd_data_d  = wb_dat_o;
          end
          if (last_beat) begin
            state_d = StFin;
          end else if (we_q) begin
            state_d = StWdata;
          end
        end else if (tmo_q == TW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= 3'd0;
      beat_q     <= 3'd0;
      sel_q      <= '0;
      wdat_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      sel_q      <= sel_d;
      wdat_q     <= wdat_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Held off while RESETN is low so no command is offered during reset.
  assign req_ready = RESETN && (state_q == StIdle);
  assign wr_ready  = (state_q == StWdata);
  assign wb_cyc_i  = (state_q == StWdata) || (state_q == StBus);
  assign wb_stb_i  = (state_q == StBus);
  assign wb_we_i   = we_q;
  assign wb_addr_i = addr_q;
  assign wb_dat_i  = wdat_q;
  assign wb_sel_i  = sel_q;
  assign wb_cti_i  = cti_for(len_q, beat_q);
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;
  assign done      = (state_q == StFin);
  assign err_tmo   = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: directed bursts plus randomized traffic
// against a Wishbone slave model with random wait states and stray acks.
module tb_wb_burst_master;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 26;
  localparam int unsigned TMO = 255;
  localparam int unsigned SW  = DW / 8;

  logic          sys_clk = 1'b0;
  logic          RESETN  = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_len = 3'd0;
  logic [SW-1:0] req_sel = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;
  logic          err_tmo;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_dat_i;
  logic [SW-1:0] wb_sel_i;
  logic [2:0]    wb_cti_i;
  logic          wb_ack_o = 1'b0;
  logic [DW-1:0] wb_dat_o = '0;

  always #5 sys_clk = ~sys_clk;

  wb_burst_master #(
    .DW (DW),
    .AW (AW),
    .TMO(TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .RESETN   (RESETN),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_len  (req_len),
    .req_sel  (req_sel),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done),
    .err_tmo  (err_tmo),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_addr_i(wb_addr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_cti_i (wb_cti_i),
    .wb_ack_o (wb_ack_o),
    .wb_dat_o (wb_dat_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } rd_t;

  localparam int EvDone = 0;
  localparam int EvTmo  = 1;

  beat_t bus_q[$];
  rd_t   rd_q[$];
  int    evt_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  int    wait_lo = 0;
  int    wait_hi = 0;
  int    wait_cnt = 0;
  bit    hold = 1'b0;
  bit    noise = 1'b0;
  int    acks_given = 0;

  beat_t mon_b;
  rd_t   mon_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Slave model and output monitors, all acting on the falling edge.
  always @(negedge sys_clk) begin
    if (!RESETN) begin
      wb_ack_o = 1'b0;
    end else begin
      if (rd_valid) begin
        chk("rd_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
          mon_r = rd_q.pop_front();
          chk("rd_data", rd_data, mon_r.dat);
          chk("rd_last", rd_last, mon_r.last);
        end
      end
      if (done) begin
        chk("done_expected", (evt_q.size() > 0 && evt_q[0] == EvDone), 1);
        if (evt_q.size() > 0) void'(evt_q.pop_front());
      end
      if (err_tmo) begin
        chk("tmo_expected", (evt_q.size() > 0 && evt_q[0] == EvTmo), 1);
        if (evt_q.size() > 0) void'(evt_q.pop_front());
      end
      if (wr_ready) chk("wdata_cyc_no_stb", {wb_cyc_i, wb_stb_i}, 2'b10);

      if (wb_cyc_i && wb_stb_i) begin
        if (hold) begin
          wb_ack_o = 1'b0;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
          wb_ack_o = 1'b0;
        end else begin
          wb_ack_o = 1'b1;
          wb_dat_o = $urandom;
          wait_cnt = int'($urandom_range(wait_hi, wait_lo));
          acks_given++;
          chk("beat_expected", bus_q.size() > 0, 1);
          if (bus_q.size() > 0) begin
            mon_b = bus_q.pop_front();
            chk("beat_addr", wb_addr_i, mon_b.addr);
            chk("beat_we", wb_we_i, mon_b.we);
            chk("beat_sel", wb_sel_i, mon_b.sel);
            chk("beat_cti", wb_cti_i, mon_b.cti);
            if (mon_b.we) chk("beat_wdata", wb_dat_i, mon_b.dat);
            else rd_q.push_back('{dat: wb_dat_o, last: mon_b.last});
          end
        end
      end else begin
        // Stray acks outside a strobe must be ignored by the master.
        wb_ack_o = noise && ($urandom_range(0, 1) == 1);
        wb_dat_o = $urandom;
      end
    end
  end

  task automatic start_cmd(input logic we, input logic [AW-1:0] addr, input logic [2:0] len,
                           input logic [SW-1:0] sel, input int wdly, input bit exp_tmo);
    logic [DW-1:0] wd[8];
    beat_t b;
    int d;
    for (int i = 0; i <= int'(len); i++) begin
      wd[i]  = $urandom;
      b.addr = AW'((64'(addr) + 64'(i)) % (64'd1 << AW));
      b.we   = we;
      b.sel  = sel;
      b.cti  = (len == 3'd0) ? 3'b000 : ((i == int'(len)) ? 3'b111 : 3'b010);
      b.dat  = wd[i];
      b.last = (i == int'(len));
      if (!exp_tmo) bus_q.push_back(b);
    end
    evt_q.push_back(exp_tmo ? EvTmo : EvDone);

    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_sel   = sel;
    req_valid = 1'b1;
    for (int t = 0; t < 100 && !req_ready; t++) step();
    chk("req_accept", req_ready, 1);
    step();
    req_valid = 1'b0;

    if (we) begin
      for (int i = 0; i <= int'(len); i++) begin
        d = (wdly < 0) ? int'($urandom_range(0, 3)) : wdly;
        wr_valid = 1'b0;
        repeat (d) step();
        wr_valid = 1'b1;
        wr_data  = wd[i];
        for (int t = 0; t < 300 && !wr_ready; t++) step();
        chk("wr_accept", wr_ready, 1);
        step();
        wr_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 2000 && (evt_q.size() + bus_q.size() + rd_q.size()) != 0; t++) step();
    chk("burst_complete", evt_q.size() + bus_q.size() + rd_q.size(), 0);
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {req_ready, wr_ready, wb_cyc_i, wb_stb_i, wb_we_i, rd_valid, rd_last,
                        done, err_tmo}, 0);
    chk({tag, "_addr"}, wb_addr_i, 0);
    chk({tag, "_wdat"}, wb_dat_i, 0);
    chk({tag, "_sel"}, wb_sel_i, 0);
    chk({tag, "_cti"}, wb_cti_i, 0);
    chk({tag, "_rdata"}, rd_data, 0);
  endtask

  initial begin
    int lat;
    int cnt;
    int a0;
    logic [AW-1:0] ra;

    repeat (3) step();
    chk_reset("por");
    RESETN = 1'b1;
    step();
    chk("idle_ready", req_ready, 1);

    // Read len=3 at 0x100 with an ack every cycle.
    start_cmd(1'b0, AW'('h100), 3'd3, 4'hF, 0, 1'b0);
    wait_done();

    // Single-beat read: request to ready-again in three cycles.
    start_cmd(1'b0, AW'($urandom), 3'd0, 4'hF, 0, 1'b0);
    lat = 1;
    while (!req_ready && lat < 20) begin
      step();
      lat++;
    end
    chk("rd_len0_latency", lat, 3);
    wait_done();

    // Single-beat write with write data held back five cycles.
    start_cmd(1'b1, AW'($urandom), 3'd0, 4'h5, 5, 1'b0);
    wait_done();

    // Three-beat write against a slave with two wait states per beat.
    wait_lo = 2;
    wait_hi = 2;
    wait_cnt = 2;
    a0 = acks_given;
    start_cmd(1'b1, AW'($urandom), 3'd2, 4'hC, 0, 1'b0);
    wait_done();
    chk("wr3_acks", acks_given - a0, 3);

    // Address wrap at the top of the word space.
    wait_lo = 0;
    wait_hi = 0;
    wait_cnt = 0;
    start_cmd(1'b0, '1, 3'd1, 4'hF, 0, 1'b0);
    wait_done();
    start_cmd(1'b1, '1, 3'd1, 4'h3, 1, 1'b0);
    wait_done();

    // Silent slave: abort after TMO strobe cycles.
    hold = 1'b1;
    start_cmd(1'b0, AW'($urandom), 3'd2, 4'hF, 0, 1'b1);
    cnt = 0;
    for (int t = 0; t < 400; t++) begin
      if (err_tmo) break;
      if (wb_stb_i) cnt++;
      step();
    end
    chk("tmo_cycles", cnt, TMO);
    chk("tmo_pulse", err_tmo, 1);
    chk("tmo_bus_idle", {wb_cyc_i, wb_stb_i}, 0);
    chk("tmo_req_ready", req_ready, 1);
    step();
    chk("tmo_one_cycle", err_tmo, 0);
    hold = 1'b0;
    wait_done();

    // Reset in the middle of a six-beat read, after two beats.
    a0 = acks_given;
    start_cmd(1'b0, AW'($urandom), 3'd5, 4'hF, 0, 1'b0);
    for (int t = 0; t < 50 && (acks_given - a0) < 2; t++) step();
    chk("mid_two_beats", acks_given - a0, 2);
    hold   = 1'b1;
    RESETN = 1'b0;
    step();
    chk_reset("midrst");
    bus_q.delete();
    rd_q.delete();
    evt_q.delete();
    step();
    RESETN = 1'b1;
    hold   = 1'b0;
    step();
    start_cmd(1'b0, AW'($urandom), 3'd2, 4'h9, 0, 1'b0);
    wait_done();

    // Randomized traffic with wait states and stray acks.
    wait_lo = 0;
    wait_hi = 2;
    noise   = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = AW'($urandom);
      if ($urandom_range(0, 3) == 0) ra = '1 - AW'($urandom_range(0, 4));
      start_cmd(1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)),
                SW'($urandom), -1, 1'b0);
      wait_done();
    end
    noise = 1'b0;
    step();
    chk("final_idle", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
